axil_timer: RTL and testbench
=============================

AXIL_TIMER -- requirements
Module: axil_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-lite address width; only addr[4:2] is decoded.
REQ-002 SHALL have parameter TIMER_WIDTH, default 64, mtime/mtimecmp width (fixed 64 in this revision).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all state on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 s_axilite_awaddr  in  ADDR_WIDTH  write address; s_axilite_awprot  in  3  ignored.
REQ-006 s_axilite_awvalid  in  1 / s_axilite_awready  out  1  AW handshake.
REQ-007 s_axilite_wdata  in  32 / s_axilite_wstrb  in  4 / s_axilite_wvalid  in  1 / s_axilite_wready  out  1  W channel.
REQ-008 s_axilite_bresp  out  2 / s_axilite_bvalid  out  1 / s_axilite_bready  in  1  B channel.
REQ-009 s_axilite_araddr  in  ADDR_WIDTH / s_axilite_arprot  in  3 (ignored) / s_axilite_arvalid  in  1 / s_axilite_arready  out  1  AR channel.
REQ-010 s_axilite_rdata  out  32 / s_axilite_rresp  out  2 / s_axilite_rvalid  out  1 / s_axilite_rready  in  1  R channel.
REQ-011 irq  out  1  timer interrupt, registered.

Function
REQ-012 Register map (byte offset): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bit1 IRQ_EN), 0x14 PRESCALE (macro-dependent), others unmapped.
REQ-013 Write: awready=wready=1 in the same cycle only when awvalid && wvalid && !bvalid; register updated on that edge; bvalid=1 next cycle, held until bready.
REQ-014 Read: arready=1 when arvalid && !rvalid; rdata/rresp registered, rvalid=1 next cycle, held stable until rready.
REQ-015 AW without W (or W without AW) SHALL not be accepted; no skid buffering.
REQ-016 wstrb SHALL gate byte lanes individually; wstrb=0 updates nothing, still responds OKAY.
REQ-017 resp SHALL be OKAY (2'b00) for mapped offsets, SLVERR (2'b10) for unmapped; unmapped reads return 0, unmapped writes have no effect.
REQ-018 mtime SHALL increment by 1 per tick while EN=1; tick = every cycle (or per prescaler, REQ-025); wraps 2^64-1 -> 0.
REQ-019 Software write to MTIME_LO/HI SHALL take priority over the increment in the same cycle; untouched half keeps its pre-increment value.
REQ-020 irq SHALL be 1 the cycle after (IRQ_EN && mtime >= mtimecmp) becomes true, unsigned 64-bit compare; deasserts the cycle after it becomes false.
REQ-021 Simultaneous read and write accepted in same cycle to same register: read returns pre-write value.

Reset
REQ-022 On rst: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescale counter=0, PRESCALE=0.
REQ-023 On rst: awready, wready, arready, bvalid, rvalid, irq=0; bresp, rresp, rdata=0; in-flight responses discarded.

Configuration
REQ-024 Macro AXIL_TIMER_PRESCALER_EN SHALL select the prescaler feature.
REQ-025 Defined: 0x14 PRESCALE (16-bit, bits[15:0], rest read 0) mapped; tick when prescale counter == PRESCALE, then counter resets to 0; PRESCALE=0 means tick every cycle; writing PRESCALE clears counter.
REQ-026 Undefined: 0x14 unmapped (SLVERR), tick every cycle, no prescaler logic.

Structure
REQ-027 Package axil_timer_pkg SHALL hold register offsets, CTRL bit indices, RESP_OKAY/RESP_SLVERR constants, reset value of mtimecmp.
REQ-028 Sub-module axil_timer_counter SHALL hold mtime, prescaler, compare and irq register; axil_timer holds AXI-lite FSM and register decode.

Verification
REQ-029 Write CTRL=0x3, MTIMECMP=10, MTIME=0 -> irq rises exactly 11 cycles after EN write completes (mtime reaches 10 + 1 reg stage); bresp=OKAY each.
REQ-030 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF, EN=1 -> reads show wrap to 0x0000_0000_0000_000x, no X.
REQ-031 Read 0x18, write 0x1C -> rresp=SLVERR, rdata=0; bresp=SLVERR; other registers unchanged.
REQ-032 Write MTIMECMP_LO with wstrb=0x2, wdata=0xAABBCCDD -> MTIMECMP_LO reads 0xFFFFCCFF.
REQ-033 Hold bready=0 for 5 cycles after a write -> bvalid stays 1, awready/wready stay 0, second write accepted after bready.
REQ-034 With AXIL_TIMER_PRESCALER_EN, PRESCALE=3, EN=1 -> mtime advances by 1 every 4 cycles; assert rst mid-count -> all REQ-022/023 values next cycle.

Source files
------------

// File: rtl/axil_timer_pkg.sv
// Shared constants, FSM state types and byte-lane helper for the AXI-lite timer.
package axil_timer_pkg;

  // Register word index (byte offset >> 2)
  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;
  localparam logic [2:0] REG_PRESCALE    = 3'd5;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_timer_if.sv
// AXI-lite slave bus bundle used by axil_timer.
interface axil_timer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_timer_counter.sv
// mtime counter, optional prescaler (AXIL_TIMER_PRESCALER_EN), compare and irq register.
module axil_timer_counter
  import axil_timer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   irq_en,
  input  logic [TIMER_WIDTH-1:0] mtimecmp,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   mtime_lo_we,
  input  logic                   mtime_hi_we,
`ifdef AXIL_TIMER_PRESCALER_EN
  input  logic                   prescale_we,
  output logic [15:0]            prescale,
`endif
  output logic [TIMER_WIDTH-1:0] mtime,
  output logic                   irq
);

  logic                   tick;
  logic [TIMER_WIDTH-1:0] mtime_d;

`ifdef AXIL_TIMER_PRESCALER_EN
  logic [15:0] pcnt_q;
  logic [15:0] prescale_wr;
  logic [15:0] prescale_hi_unused;

  assign {prescale_hi_unused, prescale_wr} = apply_strb({16'h0, prescale}, wdata, wstrb);
  assign tick = en && (pcnt_q == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      pcnt_q   <= '0;
    end else if (prescale_we) begin
      prescale <= prescale_wr;
      pcnt_q   <= '0;
    end else if (en) begin
      pcnt_q <= tick ? '0 : pcnt_q + 16'd1;
    end
  end
`else
  assign tick = en;
`endif

  // A software write freezes the whole counter for that cycle: the written
  // half takes the new bytes, everything else holds its pre-increment value.
  always_comb begin
    mtime_d = tick ? mtime + TIMER_WIDTH'(1) : mtime;
    if (mtime_lo_we || mtime_hi_we) mtime_d = mtime;
    if (mtime_lo_we) mtime_d[31:0] = apply_strb(mtime[31:0], wdata, wstrb);
    if (mtime_hi_we) mtime_d[TIMER_WIDTH-1:32] = apply_strb(mtime[TIMER_WIDTH-1:32], wdata, wstrb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      irq   <= 1'b0;
    end else begin
      mtime <= mtime_d;
      irq   <= irq_en && (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/axil_timer.sv
// AXI-lite machine timer: bus FSMs and register decode; optional PRESCALE
// register at 0x14 enabled by AXIL_TIMER_PRESCALER_EN.
module axil_timer
  import axil_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TIMER_WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  axil_timer_if.slave   s_axilite,
  output logic          irq
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                   wr_fire, rd_fire;
  logic                   wr_mapped, rd_mapped;
  logic [2:0]             wr_idx, rd_idx;
  logic [31:0]            rd_val;
  logic [1:0]             bresp_q, rresp_q;
  logic [31:0]            rdata_q;
  logic                   ctrl_en, ctrl_irq_en;
  logic [TIMER_WIDTH-1:0] mtimecmp, mtime;
  logic                   mtime_lo_we, mtime_hi_we, cmp_lo_we, cmp_hi_we, ctrl_we;
`ifdef AXIL_TIMER_PRESCALER_EN
  logic                   prescale_we;
  logic [15:0]            prescale;
`endif

  logic unused_bus;
  assign unused_bus = ^{s_axilite.awprot, s_axilite.arprot,
                        s_axilite.awaddr[ADDR_WIDTH-1:5], s_axilite.awaddr[1:0],
                        s_axilite.araddr[ADDR_WIDTH-1:5], s_axilite.araddr[1:0]};

  assign wr_idx = s_axilite.awaddr[4:2];
  assign rd_idx = s_axilite.araddr[4:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    wr_fire = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        wr_fire = !rst && s_axilite.awvalid && s_axilite.wvalid;
        if (wr_fire) wr_next = WR_RESP;
      end
      WR_RESP: if (s_axilite.bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    rd_fire = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        rd_fire = !rst && s_axilite.arvalid;
        if (rd_fire) rd_next = RD_DATA;
      end
      RD_DATA: if (s_axilite.rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign s_axilite.awready = wr_fire;
  assign s_axilite.wready  = wr_fire;
  assign s_axilite.bvalid  = (wr_state == WR_RESP);
  assign s_axilite.bresp   = bresp_q;
  assign s_axilite.arready = rd_fire;
  assign s_axilite.rvalid  = (rd_state == RD_DATA);
  assign s_axilite.rresp   = rresp_q;
  assign s_axilite.rdata   = rdata_q;

  always_comb begin
    wr_mapped = (wr_idx <= REG_CTRL);
`ifdef AXIL_TIMER_PRESCALER_EN
    if (wr_idx == REG_PRESCALE) wr_mapped = 1'b1;
`endif
  end

  assign mtime_lo_we = wr_fire && (wr_idx == REG_MTIME_LO);
  assign mtime_hi_we = wr_fire && (wr_idx == REG_MTIME_HI);
  assign cmp_lo_we   = wr_fire && (wr_idx == REG_MTIMECMP_LO);
  assign cmp_hi_we   = wr_fire && (wr_idx == REG_MTIMECMP_HI);
  assign ctrl_we     = wr_fire && (wr_idx == REG_CTRL) && s_axilite.wstrb[0];
`ifdef AXIL_TIMER_PRESCALER_EN
  assign prescale_we = wr_fire && (wr_idx == REG_PRESCALE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp    <= MTIMECMP_RESET;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      bresp_q     <= '0;
    end else begin
      if (cmp_lo_we)
        mtimecmp[31:0] <= apply_strb(mtimecmp[31:0], s_axilite.wdata, s_axilite.wstrb);
      if (cmp_hi_we)
        mtimecmp[TIMER_WIDTH-1:32] <= apply_strb(mtimecmp[TIMER_WIDTH-1:32],
                                                 s_axilite.wdata, s_axilite.wstrb);
      if (ctrl_we) begin
        ctrl_en     <= s_axilite.wdata[CTRL_EN_BIT];
        ctrl_irq_en <= s_axilite.wdata[CTRL_IRQ_EN_BIT];
      end
      if (wr_fire) bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rd_val    = '0;
    rd_mapped = 1'b1;
    case (rd_idx)
      REG_MTIME_LO:    rd_val = mtime[31:0];
      REG_MTIME_HI:    rd_val = mtime[TIMER_WIDTH-1:32];
      REG_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp[TIMER_WIDTH-1:32];
      REG_CTRL:        rd_val = {30'h0, ctrl_irq_en, ctrl_en};
`ifdef AXIL_TIMER_PRESCALER_EN
      REG_PRESCALE:    rd_val = {16'h0, prescale};
`endif
      default:         rd_mapped = 1'b0;
    endcase
  end

  // Read data is captured from the current register values, so a write
  // accepted on the same edge is not visible in this response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= '0;
    end else if (rd_fire) begin
      rdata_q <= rd_val;
      rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axil_timer_counter #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (ctrl_en),
    .irq_en      (ctrl_irq_en),
    .mtimecmp    (mtimecmp),
    .wdata       (s_axilite.wdata),
    .wstrb       (s_axilite.wstrb),
    .mtime_lo_we (mtime_lo_we),
    .mtime_hi_we (mtime_hi_we),
`ifdef AXIL_TIMER_PRESCALER_EN
    .prescale_we (prescale_we),
    .prescale    (prescale),
`endif
    .mtime       (mtime),
    .irq         (irq)
  );

endmodule

// File: tb/tb_axil_timer.sv
// Directed self-checking bench for axil_timer; prescaler scenario runs when
// AXIL_TIMER_PRESCALER_EN is defined.
module tb_axil_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  axil_timer_if #(.ADDR_WIDTH(32)) bus ();

  axil_timer #(.ADDR_WIDTH(32), .TIMER_WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axilite (bus.slave),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output int unsigned hs);
    int n = 0;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    while (!(bus.awready && bus.wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr=%h got=no_ready exp=ready", addr);
    end
    @(posedge clk); #1;
    hs = cyc;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h got=no_ready exp=ready", addr);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin @(posedge clk); #1; n++; end
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1;
    bus.awaddr = 32'h0; bus.wdata = 32'h1234; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 32'h0; bus.arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin errors++;
      $display("FAIL rst_ready got=%b exp=000", {bus.awready, bus.wready, bus.arready}); end
    checks++; if ({bus.bvalid, bus.rvalid, irq} !== 3'b000) begin errors++;
      $display("FAIL rst_valid got=%b exp=000", {bus.bvalid, bus.rvalid, irq}); end
    checks++; if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin errors++;
      $display("FAIL rst_resp got=%h exp=0", {bus.bresp, bus.rresp, bus.rdata}); end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; rst = 1'b0;
    axi_read(32'h08, d, r);
    checks++; if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin errors++;
      $display("FAIL rst_cmp_lo got=%h/%b exp=ffffffff/00", d, r); end
    axi_read(32'h0C, d, r);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL rst_cmp_hi got=%h exp=ffffffff", d); end
    axi_read(32'h10, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", d); end
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mtime got=%h exp=0", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int unsigned hs;
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, r, hs);
    axi_write(32'h08, 32'hAABB_CCDD, 4'h2, r, hs);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strb_bresp got=%b exp=00", r); end
    axi_read(32'h08, d, r);
    checks++; if (d !== 32'hFFFF_CCFF) begin errors++;
      $display("FAIL strb_lane got=%h exp=ffffccff", d); end
    axi_write(32'h0C, 32'h0, 4'h0, r, hs);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL strb0_bresp got=%b exp=00", r); end
    axi_read(32'h0C, d, r);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL strb0_keep got=%h exp=ffffffff", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; int unsigned hs;
    axi_read(32'h18, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL unmap_rd got=%h/%b exp=0/10", d, r); end
    axi_write(32'h1C, 32'h0, 4'hF, r, hs);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL unmap_wr got=%b exp=10", r); end
    axi_read(32'h08, d, r);
    checks++; if (d !== 32'hFFFF_CCFF) begin errors++;
      $display("FAIL unmap_side got=%h exp=ffffccff", d); end
`ifndef AXIL_TIMER_PRESCALER_EN
    axi_read(32'h14, d, r);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL presc_unmap got=%h/%b exp=0/10", d, r); end
`endif
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r; logic [1:0] rs; int unsigned hs, e; int n;
    rs = 2'b00;
    axi_write(32'h0C, 32'h0, 4'hF, r, hs); rs |= r;
    axi_write(32'h08, 32'd10, 4'hF, r, hs); rs |= r;
    axi_write(32'h00, 32'h0, 4'hF, r, hs); rs |= r;
    axi_write(32'h04, 32'h0, 4'hF, r, hs); rs |= r;
    axi_write(32'h10, 32'h3, 4'hF, r, e); rs |= r;
    checks++; if (rs !== 2'b00) begin errors++; $display("FAIL irq_bresp got=%b exp=00", rs); end
    n = 0;
    while (irq !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (cyc - e !== 11) begin errors++;
      $display("FAIL irq_latency got=%0d exp=11", cyc - e); end
    axi_write(32'h10, 32'h0, 4'hF, r, hs);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic [1:0] r; int unsigned hs, e, s;
    axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, r, hs);
    axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, r, hs);
    axi_read(32'h04, d, r);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL wrap_pre got=%h exp=ffffffff", d); end
    axi_write(32'h10, 32'h1, 4'hF, r, e);
    axi_write(32'h10, 32'h0, 4'hF, r, s);
    axi_read(32'h04, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=0", d); end
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'(s - e - 1)) begin errors++;
      $display("FAIL wrap_lo got=%h exp=%h", d, 32'(s - e - 1)); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    bus.awaddr = 32'h08; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 32'h08; bus.arvalid = 1'b1;
    #1;
    checks++; if ({bus.awready, bus.arready} !== 2'b11) begin errors++;
      $display("FAIL simul_ready got=%b exp=11", {bus.awready, bus.arready}); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'd10) begin errors++;
      $display("FAIL simul_old got=%b/%h exp=1/0000000a", bus.rvalid, bus.rdata); end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(32'h08, d, r);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL simul_new got=%h exp=55", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; logic bad;
    @(negedge clk);
    bus.awaddr = 32'h0C; bus.wdata = 32'h11; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wdata = 32'h22;
    bad = 1'b0;
    repeat (5) begin
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 1'b0) begin errors++;
      $display("FAIL b2b_hold got=stall_broken exp=bvalid_held"); end
    checks++; if (bus.bresp !== 2'b00) begin errors++;
      $display("FAIL b2b_bresp got=%b exp=00", bus.bresp); end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checks++; if ({bus.bvalid, bus.awready} !== 2'b01) begin errors++;
      $display("FAIL b2b_second got=%b exp=01", {bus.bvalid, bus.awready}); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    axi_read(32'h0C, d, r);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL b2b_data got=%h exp=22", d); end
  endtask

`ifdef AXIL_TIMER_PRESCALER_EN
  task automatic test_prescaler();
    logic [31:0] d; logic [1:0] r; int unsigned hs, e, s;
    axi_write(32'h14, 32'hFFFF_1234, 4'hF, r, hs);
    axi_read(32'h14, d, r);
    checks++; if (d !== 32'h1234 || r !== 2'b00) begin errors++;
      $display("FAIL presc_rd got=%h/%b exp=1234/00", d, r); end
    axi_write(32'h00, 32'h0, 4'hF, r, hs);
    axi_write(32'h04, 32'h0, 4'hF, r, hs);
    axi_write(32'h14, 32'h3, 4'hF, r, hs);
    axi_write(32'h10, 32'h1, 4'hF, r, e);
    repeat (9) @(posedge clk);
    axi_write(32'h10, 32'h0, 4'hF, r, s);
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'((s - e) / 4)) begin errors++;
      $display("FAIL presc_rate got=%h exp=%h", d, 32'((s - e) / 4)); end
    axi_write(32'h10, 32'h1, 4'hF, r, hs);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int unsigned hs;
    axi_write(32'h08, 32'h0, 4'hF, r, hs);
    axi_write(32'h0C, 32'h0, 4'hF, r, hs);
    axi_write(32'h10, 32'h3, 4'hF, r, hs);
    @(negedge clk);
    bus.araddr = 32'h08; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid, irq} !== 2'b11) begin errors++;
      $display("FAIL mid_pre got=%b exp=11", {bus.rvalid, irq}); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.rvalid, bus.bvalid, irq, bus.arready} !== 4'b0000) begin errors++;
      $display("FAIL mid_flags got=%b exp=0000", {bus.rvalid, bus.bvalid, irq, bus.arready}); end
    checks++; if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0) begin errors++;
      $display("FAIL mid_data got=%h exp=0", {bus.rdata, bus.rresp, bus.bresp}); end
    @(negedge clk); rst = 1'b0; bus.arvalid = 1'b0;
    axi_read(32'h10, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_ctrl got=%h exp=0", d); end
    axi_read(32'h00, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_mtime got=%h exp=0", d); end
    axi_read(32'h0C, d, r);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL mid_cmp got=%h exp=ffffffff", d); end
`ifdef AXIL_TIMER_PRESCALER_EN
    axi_read(32'h14, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_presc got=%h exp=0", d); end
`endif
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    test_strobe();
    test_unmapped();
    test_irq();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
`ifdef AXIL_TIMER_PRESCALER_EN
    test_prescaler();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
